median: RTL and testbench

MEDIAN -- requirements
Module: median

---
 rtl/median_pkg.sv | 12 +
 rtl/median_med.sv | 23 ++
 rtl/median.sv | 54 +++++
 tb/tb_median.sv | 139 +++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// median_pkg: shared states, sizes and bypass schedule for the 3x3 median block
package median_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  localparam int N_PIX = 9;
  localparam int RUN_LEN = 40;
  localparam int PIX_W_DEF = 8;
  localparam logic [5:0] CNT_LAST = 6'(RUN_LEN - 1);
  // selection passes: 9-k compares then k rotations for k=1..4, then 4 final compares
  function automatic logic byp_at(input logic [5:0] c);
    return c inside {6'd8, 6'd16, 6'd17, 6'd24, 6'd25, 6'd26, 6'd32, 6'd33, 6'd34, 6'd35};
  endfunction
endpackage

// File: rtl/median_med.sv
// median_med: nine-entry rotating ring with one compare-exchange at the tail; DO holds the running pass winner
module median_med
  import median_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             CLK,
  input  logic             DSI,
  input  logic             BYP,
  input  logic [PIX_W-1:0] DI,
  output logic [PIX_W-1:0] DO
);
  logic [PIX_W-1:0] s [N_PIX];
  logic swap;
  assign swap = s[N_PIX-2] > s[N_PIX-1];
  assign DO = s[N_PIX-1];
  // compare keeps the larger in the tail and recirculates the smaller; bypass is a plain rotation
  always_ff @(posedge CLK) begin
    s[0] <= DSI ? DI : (BYP || swap) ? s[N_PIX-1] : s[N_PIX-2];
    for (int i = 1; i < N_PIX - 1; i++) s[i] <= s[i-1];
    s[N_PIX-1] <= (BYP || swap) ? s[N_PIX-2] : s[N_PIX-1];
  end
endmodule

// File: rtl/median.sv
// median: window sequencer around the median datapath; one DSO pulse 40 cycles after each load ends
module median
  import median_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [PIX_W-1:0] DI,
  input  logic             DSI,
  output logic [PIX_W-1:0] DO,
  output logic             DSO
);
  state_t state, state_nx;
  logic [5:0] cnt, cnt_nx;
  logic byp;
  // the LOAD cycle that sees DSI low is schedule step 0, so RUN is entered at step 1
  always_comb begin
    state_nx = state;
    cnt_nx = '0;
    byp = DSI;
    case (state)
      IDLE: state_nx = DSI ? LOAD : IDLE;
      LOAD: begin
        state_nx = DSI ? LOAD : RUN;
        cnt_nx = DSI ? 6'd0 : 6'd1;
      end
      RUN: begin
        byp = byp_at(cnt);
        cnt_nx = cnt + 6'd1;
        state_nx = (cnt == CNT_LAST) ? DONE : RUN;
      end
      DONE: state_nx = DSI ? LOAD : IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      cnt <= '0;
      DSO <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      DSO <= state_nx == DONE;
    end
  end
  median_med #(.PIX_W(PIX_W)) MED (
    .CLK(CLK),
    .DSI(DSI),
    .BYP(byp),
    .DI (DI),
    .DO (DO)
  );
endmodule

// File: tb/tb_median.sv
// tb_median: directed and random windows against hand-computed and sort-based medians
module tb_median;
  import median_pkg::*;
  logic CLK, nRST, DSI, DSO;
  logic [7:0] DI, DO;
  logic [7:0] pix [9];
  int checks = 0, errors = 0, cyc = 0, dso_cnt = 0, dso_cyc = 0, prev_cyc, base;

  median dut (.CLK(CLK), .nRST(nRST), .DI(DI), .DSI(DSI), .DO(DO), .DSO(DSO));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) if (DSO === 1'b1) dso_cnt <= dso_cnt + 1;

  initial begin
    #5_000_000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model();
    logic [7:0] a [9];
    logic [7:0] t;
    a = pix;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    return a[4];
  endfunction

  // loads pix for len cycles starting in the current cycle, then waits for DSO
  task automatic window(input string tag, input logic [7:0] exp, input bit chk, input int len, input int glitch);
    int n;
    for (int i = 0; i < len; i++) begin
      DI = pix[i % 9];
      DSI = 1'b1;
      tick();
      if (i == 0) check({tag, "_dso_gap"}, {31'd0, DSO}, 32'd0);
    end
    n = 0;
    do begin
      DSI = (glitch != 0 && n == glitch);
      DI = 8'hA5;
      tick();
      n++;
    end while (DSO !== 1'b1 && n < 60);
    DSI = 1'b0;
    check({tag, "_latency"}, n, 40);
    if (chk) check({tag, "_do"}, {24'd0, DO}, {24'd0, exp});
    dso_cyc = cyc;
  endtask

  initial begin
    nRST = 1'b0;
    DSI = 1'b0;
    DI = 8'd0;
    tick();
    check("rst_dso", {31'd0, DSO}, 32'd0);
    check("rst_state", {30'd0, dut.state}, {30'd0, IDLE});
    check("rst_cnt", {26'd0, dut.cnt}, 32'd0);
    nRST = 1'b1;
    tick();

    pix = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    window("ascend", 8'd5, 1'b1, 9, 0);
    tick();
    check("one_cycle_dso", {31'd0, DSO}, 32'd0);

    pix = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd128};
    window("extremes", 8'd128, 1'b1, 9, 0);
    tick();

    pix = '{9{8'd42}};
    window("dups", 8'd42, 1'b1, 9, 0);
    prev_cyc = dso_cyc;
    pix = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    window("b2b", 8'd5, 1'b1, 9, 0);
    check("b2b_spacing", dso_cyc - prev_cyc, 49);
    tick();

    pix = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6, 8'd5};
    for (int i = 0; i < 9; i++) begin
      DI = pix[i];
      DSI = 1'b1;
      tick();
    end
    DSI = 1'b0;
    base = dso_cnt;
    repeat (20) tick();
    nRST = 1'b0;
    #1;
    check("abort_dso", {31'd0, DSO}, 32'd0);
    check("abort_state", {30'd0, dut.state}, {30'd0, IDLE});
    repeat (2) tick();
    nRST = 1'b1;
    repeat (50) tick();
    check("abort_no_pulse", dso_cnt - base, 0);

    pix = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
    window("after_abort", 8'd50, 1'b1, 9, 0);
    tick();

    window("glitch", 8'd0, 1'b0, 9, 10);
    tick();
    window("short_load", 8'd0, 1'b0, 5, 0);
    tick();
    window("long_load", 8'd0, 1'b0, 12, 0);
    tick();

    base = dso_cnt;
    for (int w = 0; w < 1000; w++) begin
      for (int i = 0; i < 9; i++)
        pix[i] = (w % 4 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      window("random", model(), 1'b1, 9, 0);
    end
    tick();
    tick();
    check("random_dso_count", dso_cnt - base, 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
